// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared timing constants for the VGA timing generator: default 640x480@60
// porch/sync widths, derived line/frame totals, counter and coordinate widths,
// and the largest totals the counters can hold.
package vga_timing_pkg;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;

  localparam int HT_DEF = H_SYNC_DEF + H_BP_DEF + H_ACTIVE_DEF + H_FP_DEF;
  localparam int VT_DEF = V_SYNC_DEF + V_BP_DEF + V_ACTIVE_DEF + V_FP_DEF;

  localparam int COORD_W = 10;
  localparam int HC_W    = 11;
  localparam int VC_W    = 10;
  localparam int HT_MAX  = 2048;
  localparam int VT_MAX  = 1024;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// Modulo-TOTAL up-counter used for one raster axis.
// Ports:
//   clock   - rising-edge clock
//   reset_n - asynchronous active-low reset, clears count
//   enable  - advance by one when high
//   count   - current position, 0..TOTAL-1
//   wrap    - high when enabled at TOTAL-1 (count returns to 0 on this edge)
module vga_axis_counter #(
  parameter int TOTAL = 800,
  parameter int W     = 11
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         wrap
);
  logic at_end;

  assign at_end = (count == W'(TOTAL - 1));
  assign wrap   = enable && at_end;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (enable) begin
      count <= at_end ? '0 : count + W'(1);
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// VGA raster timing generator running from CLOCK_50 with a divide-by-two pixel
// strobe. Each line/frame is ordered sync, back porch, active, front porch.
// All outputs are registered and mutually aligned, one clock behind the
// counter state; they update only on PIX_CE cycles, pulses drop to 0 between.
// Ports:
//   CLOCK_50    - 50 MHz clock, rising edge
//   RESET_N     - asynchronous active-low reset
//   VGA_HS      - horizontal sync, active low
//   VGA_VS      - vertical sync, active low
//   PIX_CE      - one-cycle pixel strobe (every other clock)
//   DE          - visible pixel
//   PIX_X/PIX_Y - visible-area coordinates, 0 when DE=0
//   LINE_START  - pulse on the pixel with hc=0
//   FRAME_START - pulse on the pixel with hc=0, vc=0
//   FRAME_CNT   - 8-bit frame counter, only when VGA_TIMING_FRAME_CNT_EN is defined
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               PIX_CE,
  output logic               DE,
  output logic [COORD_W-1:0] PIX_X,
  output logic [COORD_W-1:0] PIX_Y,
  output logic               LINE_START,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic [7:0]         FRAME_CNT,
`endif
  output logic               FRAME_START
);
  localparam int HT          = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int VT          = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_ACT_START = H_SYNC + H_BP;
  localparam int H_ACT_END   = HT - H_FP;
  localparam int V_ACT_START = V_SYNC + V_BP;
  localparam int V_ACT_END   = VT - V_FP;

  generate
    if (HT > HT_MAX || VT > VT_MAX) begin : g_bad_timing
      $error("vga_timing_gen: HT must be <= 2048 and VT <= 1024");
    end
  endgenerate

  logic            div;
  logic [HC_W-1:0] hc;
  logic [VC_W-1:0] vc;
  logic            hc_wrap;
  // The frame pulse is decoded from the counter values, so the vertical
  // wrap has no consumer.
  logic            vc_wrap_unused;
  logic            de_next;
  logic            line_next;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) div <= 1'b0;
    else          div <= ~div;
  end

  vga_axis_counter #(.TOTAL(HT), .W(HC_W)) u_hc (
    .clock   (CLOCK_50),
    .reset_n (RESET_N),
    .enable  (div),
    .count   (hc),
    .wrap    (hc_wrap)
  );

  vga_axis_counter #(.TOTAL(VT), .W(VC_W)) u_vc (
    .clock   (CLOCK_50),
    .reset_n (RESET_N),
    .enable  (hc_wrap),
    .count   (vc),
    .wrap    (vc_wrap_unused)
  );

  assign de_next = (hc >= HC_W'(H_ACT_START)) && (hc < HC_W'(H_ACT_END)) &&
                   (vc >= VC_W'(V_ACT_START)) && (vc < VC_W'(V_ACT_END));
  assign line_next = (hc == '0);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      PIX_CE      <= 1'b0;
      DE          <= 1'b0;
      PIX_X       <= '0;
      PIX_Y       <= '0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      PIX_CE      <= div;
      LINE_START  <= div && line_next;
      FRAME_START <= div && line_next && (vc == '0);
      if (div) begin
        VGA_HS <= (hc >= HC_W'(H_SYNC));
        VGA_VS <= (vc >= VC_W'(V_SYNC));
        DE     <= de_next;
        PIX_X  <= de_next ? COORD_W'(hc - HC_W'(H_ACT_START)) : '0;
        PIX_Y  <= de_next ? COORD_W'(vc - VC_W'(V_ACT_START)) : '0;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Counts alongside FRAME_START, so the k-th frame pulse shows k mod 256.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N)                          FRAME_CNT <= '0;
    else if (div && line_next && vc == '0) FRAME_CNT <= FRAME_CNT + 8'd1;
  end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;
  logic       CLOCK_50;
  logic       RESET_N;
  logic       VGA_HS, VGA_VS, PIX_CE, DE, LINE_START, FRAME_START;
  logic [9:0] PIX_X, PIX_Y;
  int         errors = 0;
  int         checks = 0;

  // Horizontal at defaults (1600 clocks/line); vertical shrunk to 10 lines
  // (sync 2, bp 3, active 4, fp 1) so whole frames fit the cycle budget.
  localparam int LINE_CLK  = 1600;
  localparam int FRAME_CLK = 16000;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] FRAME_CNT;
  logic       hs2, vs2, ce2, de2, ls2, fs2;
  logic [9:0] x2, y2;
  logic [7:0] fcnt2;
`endif

  vga_timing_gen #(
    .V_SYNC(2), .V_BP(3), .V_ACTIVE(4), .V_FP(1)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .PIX_CE      (PIX_CE),
    .DE          (DE),
    .PIX_X       (PIX_X),
    .PIX_Y       (PIX_Y),
    .LINE_START  (LINE_START),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .FRAME_CNT   (FRAME_CNT),
`endif
    .FRAME_START (FRAME_START)
  );

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Tiny raster: HT=5, VT=4 -> 40 clocks per frame.
  vga_timing_gen #(
    .H_SYNC(1), .H_BP(1), .H_ACTIVE(2), .H_FP(1),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(1), .V_FP(1)
  ) dut_small (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .VGA_HS      (hs2),
    .VGA_VS      (vs2),
    .PIX_CE      (ce2),
    .DE          (de2),
    .PIX_X       (x2),
    .PIX_Y       (y2),
    .LINE_START  (ls2),
    .FRAME_CNT   (fcnt2),
    .FRAME_START (fs2)
  );
`endif

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic test_reset();
    int n;
    RESET_N = 1'b0;
    repeat (3) begin
      @(negedge CLOCK_50);
      checks++;
      if (VGA_HS !== 1'b1 || VGA_VS !== 1'b1 || DE !== 1'b0 || PIX_CE !== 1'b0 ||
          LINE_START !== 1'b0 || FRAME_START !== 1'b0 || PIX_X !== 10'd0 || PIX_Y !== 10'd0) begin
        errors++;
        $display("FAIL reset_values: hs=%b vs=%b de=%b ce=%b ls=%b fs=%b x=%0d y=%0d, required hs=1 vs=1 de=0 ce=0 ls=0 fs=0 x=0 y=0",
                 VGA_HS, VGA_VS, DE, PIX_CE, LINE_START, FRAME_START, PIX_X, PIX_Y);
      end
    end
    RESET_N = 1'b1;
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (PIX_CE !== 1'b1 && n < 8);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL release_latency: first PIX_CE after %0d clocks, required 2", n);
    end
    checks++;
    if (FRAME_START !== 1'b1 || LINE_START !== 1'b1 || VGA_HS !== 1'b0 || VGA_VS !== 1'b0 || DE !== 1'b0) begin
      errors++;
      $display("FAIL release_first_pixel: fs=%b ls=%b hs=%b vs=%b de=%b, required fs=1 ls=1 hs=0 vs=0 de=0",
               FRAME_START, LINE_START, VGA_HS, VGA_VS, DE);
    end
  endtask

  // Called on the FRAME_START sample; walks one frame clock by clock.
  task automatic test_frame_timing();
    int pos, line;
    int mm_ce, mm_ls, mm_fs, mm_hs, mm_vs, mm_de, mm_xy, zero_viol;
    int hs_low_l0, de_l5, de_first_pos, de_lines, vs_low;
    int first_x, first_y, last_x, last_y;
    bit got_first, line_de;
    bit exp_ce, exp_ls, exp_fs, exp_hs, exp_vs, exp_de;
    int exp_x, exp_y;
    mm_ce = 0; mm_ls = 0; mm_fs = 0; mm_hs = 0; mm_vs = 0; mm_de = 0; mm_xy = 0; zero_viol = 0;
    hs_low_l0 = 0; de_l5 = 0; de_first_pos = -1; de_lines = 0; vs_low = 0;
    first_x = -1; first_y = -1; last_x = -1; last_y = -1; got_first = 0; line_de = 0;
    for (int k = 0; k < FRAME_CLK; k++) begin
      pos    = k % LINE_CLK;
      line   = k / LINE_CLK;
      exp_ce = (k % 2 == 0);
      exp_ls = (pos == 0) && exp_ce;
      exp_fs = (k == 0);
      exp_hs = !(pos < 192);
      exp_vs = !(line < 2);
      exp_de = (line >= 5) && (line <= 8) && (pos >= 288) && (pos < 1568);
      exp_x  = exp_de ? (pos - 288) / 2 : 0;
      exp_y  = exp_de ? line - 5 : 0;
      if (PIX_CE !== exp_ce) mm_ce++;
      if (LINE_START !== exp_ls) mm_ls++;
      if (FRAME_START !== exp_fs) mm_fs++;
      if (VGA_HS !== exp_hs) mm_hs++;
      if (VGA_VS !== exp_vs) mm_vs++;
      if (DE !== exp_de) mm_de++;
      if (PIX_X !== 10'(exp_x) || PIX_Y !== 10'(exp_y)) mm_xy++;
      if (DE === 1'b0 && (PIX_X !== 10'd0 || PIX_Y !== 10'd0)) zero_viol++;
      if (line == 0 && VGA_HS === 1'b0) hs_low_l0++;
      if (VGA_VS === 1'b0) vs_low++;
      if (DE === 1'b1) begin
        line_de = 1;
        if (line == 5) begin
          de_l5++;
          if (de_first_pos < 0) de_first_pos = pos;
        end
        if (!got_first) begin
          got_first = 1; first_x = int'(PIX_X); first_y = int'(PIX_Y);
        end
        last_x = int'(PIX_X); last_y = int'(PIX_Y);
      end
      if (pos == LINE_CLK - 1) begin
        if (line_de) de_lines++;
        line_de = 0;
      end
      @(negedge CLOCK_50);
    end
    checks++; if (mm_ce !== 0) begin errors++; $display("FAIL pix_ce_pattern: %0d bad samples, required 0", mm_ce); end
    checks++; if (mm_ls !== 0) begin errors++; $display("FAIL line_start_period: %0d bad samples, required 0", mm_ls); end
    checks++; if (mm_fs !== 0) begin errors++; $display("FAIL frame_start_single: %0d bad samples, required 0", mm_fs); end
    checks++; if (mm_hs !== 0) begin errors++; $display("FAIL hs_waveform: %0d bad samples, required 0", mm_hs); end
    checks++; if (mm_vs !== 0) begin errors++; $display("FAIL vs_waveform: %0d bad samples, required 0", mm_vs); end
    checks++; if (mm_de !== 0) begin errors++; $display("FAIL de_waveform: %0d bad samples, required 0", mm_de); end
    checks++; if (mm_xy !== 0) begin errors++; $display("FAIL coords: %0d bad samples, required 0", mm_xy); end
    checks++; if (zero_viol !== 0) begin errors++; $display("FAIL coords_zero_when_blank: %0d bad samples, required 0", zero_viol); end
    checks++; if (hs_low_l0 !== 192) begin errors++; $display("FAIL hs_low_clocks: %0d, required 192", hs_low_l0); end
    checks++; if (de_l5 !== 1280) begin errors++; $display("FAIL de_high_clocks: %0d, required 1280", de_l5); end
    checks++; if (de_first_pos !== 288) begin errors++; $display("FAIL de_offset: %0d clocks after LINE_START, required 288", de_first_pos); end
    checks++; if (vs_low !== 2 * LINE_CLK) begin errors++; $display("FAIL vs_low_clocks: %0d, required %0d", vs_low, 2 * LINE_CLK); end
    checks++; if (de_lines !== 4) begin errors++; $display("FAIL de_lines: %0d, required 4", de_lines); end
    checks++;
    if (first_x !== 0 || first_y !== 0) begin
      errors++; $display("FAIL first_pixel: x=%0d y=%0d, required x=0 y=0", first_x, first_y);
    end
    checks++;
    if (last_x !== 639 || last_y !== 3) begin
      errors++; $display("FAIL last_pixel: x=%0d y=%0d, required x=639 y=3", last_x, last_y);
    end
    checks++;
    if (FRAME_START !== 1'b1 || LINE_START !== 1'b1) begin
      errors++; $display("FAIL frame_period: fs=%b ls=%b after %0d clocks, required fs=1 ls=1", FRAME_START, LINE_START, FRAME_CLK);
    end
  endtask

  // Called on a FRAME_START sample; resets at line 7, pixel 500.
  task automatic test_mid_frame_reset();
    int n;
    repeat (7 * LINE_CLK + 500 * 2) @(negedge CLOCK_50);
    checks++;
    if (DE !== 1'b1 || PIX_X !== 10'd356 || PIX_Y !== 10'd2) begin
      errors++; $display("FAIL pre_reset_pixel: de=%b x=%0d y=%0d, required de=1 x=356 y=2", DE, PIX_X, PIX_Y);
    end
    #3 RESET_N = 1'b0;
    #1;
    checks++;
    if (VGA_HS !== 1'b1 || VGA_VS !== 1'b1 || DE !== 1'b0 || PIX_CE !== 1'b0 ||
        LINE_START !== 1'b0 || FRAME_START !== 1'b0 || PIX_X !== 10'd0 || PIX_Y !== 10'd0) begin
      errors++;
      $display("FAIL async_reset: hs=%b vs=%b de=%b ce=%b ls=%b fs=%b x=%0d y=%0d, required hs=1 vs=1 rest 0",
               VGA_HS, VGA_VS, DE, PIX_CE, LINE_START, FRAME_START, PIX_X, PIX_Y);
    end
    repeat (2) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (PIX_CE !== 1'b1 && n < 8);
    checks++;
    if (n !== 2 || FRAME_START !== 1'b1) begin
      errors++; $display("FAIL restart_frame: first PIX_CE after %0d clocks fs=%b, required 2 clocks fs=1", n, FRAME_START);
    end
    repeat (LINE_CLK) @(negedge CLOCK_50);
    checks++;
    if (LINE_START !== 1'b1 || FRAME_START !== 1'b0 || VGA_VS !== 1'b0 || VGA_HS !== 1'b0) begin
      errors++; $display("FAIL restart_line1: ls=%b fs=%b vs=%b hs=%b, required ls=1 fs=0 vs=0 hs=0",
                         LINE_START, FRAME_START, VGA_VS, VGA_HS);
    end
  endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
  task automatic test_frame_cnt();
    int n;
    RESET_N = 1'b0;
    @(negedge CLOCK_50);
    checks++;
    if (fcnt2 !== 8'd0) begin errors++; $display("FAIL frame_cnt_reset: %0d, required 0", fcnt2); end
    RESET_N = 1'b1;
    for (int f = 1; f <= 256; f++) begin
      n = 0;
      while (fs2 !== 1'b1 && n < 100) begin
        @(negedge CLOCK_50);
        n++;
      end
      if (n >= 100) begin
        errors++; checks++;
        $display("FAIL frame_cnt_timeout: no FRAME_START for frame %0d, required one within 100 clocks", f);
        break;
      end
      if (f == 1 || f == 255 || f == 256) begin
        checks++;
        if (fcnt2 !== 8'(f % 256)) begin
          errors++; $display("FAIL frame_cnt_%0d: %0d, required %0d", f, fcnt2, f % 256);
        end
      end
      @(negedge CLOCK_50);
    end
  endtask
`endif

  initial begin
    RESET_N = 1'b0;
    test_reset();
    test_frame_timing();
    test_mid_frame_reset();
`ifdef VGA_TIMING_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
